// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - serial program loader and fetch port for a 32-bit instruction memory
// A little-endian word count header is followed by that many words, then the core is released.
module imem_load_ctrl #(
  parameter int DEPTH_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_instr,
  output logic        fetch_valid,
  output logic        core_start,
  output logic        loading,
  output logic        load_err,
  output logic        mem_we,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {S_HDR, S_LOAD, S_RUN, S_ERR} state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);

  state_t      state_q, state_d;
  logic        active_q;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] word_count_q, word_count_d;
  logic [5:0]  wr_ptr_q, wr_ptr_d;
  logic        wr_pend_q, wr_pend_d;
  logic        core_start_q, core_start_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        accept;
  logic [31:0] full_word;

  // active_q holds the byte interface closed until the first edge after reset release
  assign rx_ready    = active_q && (state_q == S_HDR || state_q == S_LOAD);
  assign loading     = rx_ready;
  assign load_err    = (state_q == S_ERR);
  assign accept      = rx_valid && rx_ready;
  assign full_word   = {rx_data, word_q[23:0]};
  assign core_start  = core_start_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_valid_q ? mem_dout : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_HDR;
      active_q      <= 1'b0;
      byte_cnt_q    <= 2'd0;
      word_q        <= 32'd0;
      word_count_q  <= 32'd0;
      wr_ptr_q      <= 6'd0;
      wr_pend_q     <= 1'b0;
      core_start_q  <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_q      <= 1'b1;
      byte_cnt_q    <= byte_cnt_d;
      word_q        <= word_d;
      word_count_q  <= word_count_d;
      wr_ptr_q      <= wr_ptr_d;
      wr_pend_q     <= wr_pend_d;
      core_start_q  <= core_start_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    word_count_d = word_count_q;
    wr_ptr_d     = wr_ptr_q;
    wr_pend_d    = 1'b0;
    mem_we       = 1'b0;
    mem_en       = 1'b0;
    mem_addr     = 32'd0;
    mem_din      = 32'd0;

    if (accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      word_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
    end

    // word_q still holds the completed word during its write cycle; the next byte lands at its end
    if (wr_pend_q) begin
      mem_we   = 1'b1;
      mem_en   = 1'b1;
      mem_addr = {24'd0, wr_ptr_q, 2'b00};
      mem_din  = word_q;
      wr_ptr_d = wr_ptr_q + 6'd1;
      if ({26'd0, wr_ptr_q} == word_count_q - 32'd1) begin
        state_d = S_RUN;
      end
    end

    if (accept && byte_cnt_q == 2'd3) begin
      case (state_q)
        S_HDR: begin
          word_count_d = full_word;
          wr_ptr_d     = 6'd0;
          if (full_word == 32'd0) begin
            state_d = S_RUN;
          end else if (full_word > DEPTH_W) begin
            state_d = S_ERR;
          end else begin
            state_d = S_LOAD;
          end
        end
        S_LOAD:  wr_pend_d = 1'b1;
        default: ;
      endcase
    end

    if (state_q == S_RUN) begin
      mem_en   = fetch_req;
      mem_addr = fetch_addr;
    end

    core_start_d  = (state_d == S_RUN) && (state_q != S_RUN);
    fetch_valid_d = (state_q == S_RUN) && fetch_req;
  end

endmodule
